// File: rtl/mmio_responder_pkg.sv
// Shared constants for the memory-stage IO region.
// Holds the IO base address and the byte offsets of the peripheral registers.
package mmio_responder_pkg;

  localparam logic [31:0] ADDR_IO           = 32'h8000_0000;

  localparam logic [7:0]  MMIO_UART_CTRL    = 8'h00;
  localparam logic [7:0]  MMIO_UART_RX      = 8'h04;
  localparam logic [7:0]  MMIO_UART_TX      = 8'h08;
  localparam logic [7:0]  MMIO_CYCLE_CNT    = 8'h10;
  localparam logic [7:0]  MMIO_INST_CNT     = 8'h14;
  localparam logic [7:0]  MMIO_CNT_RST      = 8'h18;
  localparam logic [7:0]  MMIO_BR_CNT       = 8'h1C;
  localparam logic [7:0]  MMIO_BR_TAKEN_CNT = 8'h20;

  // Word index used by the decoder (addr[1:0] is ignored).
  function automatic logic [5:0] reg_idx(input logic [7:0] off);
    return off[7:2];
  endfunction

endpackage

// File: rtl/mmio_responder_sync_fifo.sv
// Single-clock FIFO with combinational head output.
// A push is accepted when not full, or when full but a pop happens on the
// same edge (the head slot is freed as the new entry lands in it).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;

  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage write; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// Memory-stage IO responder: UART TX FIFO / RX holding register and
// performance counters, read data registered one cycle after the access.
// Optional feature macro: MMIO_BR_CNT_EN (branch and taken-branch counters).
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_en,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        inst_retire,
  input  logic        br_inst,
  input  logic        br_taken,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  logic [31:0] r_dout;
  logic [7:0]  r_rx_hold;
  logic        r_rx_full;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_inst_cnt;
  logic [31:0] r_br_cnt;
  logic [31:0] r_taken_cnt;

  logic [5:0]  w_idx;
  logic        w_rd;
  logic        w_wr;
  logic        w_rx_pop;
  logic        w_rx_cap;
  logic        w_cnt_clr;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic [7:0]  w_tx_head;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_idx     = addr[7:2];
  assign w_rd      = io_en && !we;
  assign w_wr      = io_en && we;
  assign w_rx_pop  = w_rd && (w_idx == reg_idx(MMIO_UART_RX)) && r_rx_full;
  assign w_rx_cap  = rx_valid && !r_rx_full;
  assign w_cnt_clr = w_wr && (w_idx == reg_idx(MMIO_CNT_RST));
  assign w_tx_push = w_wr && (w_idx == reg_idx(MMIO_UART_TX));
  assign w_tx_pop  = !w_tx_empty && tx_ready;

  assign dout      = r_dout;
  assign tx_valid  = !w_tx_empty;
  assign tx_data   = w_tx_head;
  assign rx_ready  = !r_rx_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_din   (din[7:0]),
    .i_pop   (w_tx_pop),
    .o_dout  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  // Read mux over pre-edge state; unmapped words read as zero.
  always_comb begin
    w_rdata = '0;
    case (w_idx)
      reg_idx(MMIO_UART_CTRL):    w_rdata = {30'b0, r_rx_full, !w_tx_full};
      reg_idx(MMIO_UART_RX):      w_rdata = r_rx_full ? {24'b0, r_rx_hold} : 32'b0;
      reg_idx(MMIO_CYCLE_CNT):    w_rdata = r_cycle_cnt;
      reg_idx(MMIO_INST_CNT):     w_rdata = r_inst_cnt;
      reg_idx(MMIO_BR_CNT):       w_rdata = r_br_cnt;
      reg_idx(MMIO_BR_TAKEN_CNT): w_rdata = r_taken_cnt;
      default:                    w_rdata = '0;
    endcase
  end

  // Read data register: updates only on IO reads, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_dout <= '0;
    else if (w_rd) r_dout <= w_rdata;
  end

  // RX holding register: capture when empty, cleared by a data read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_full <= 1'b0;
      r_rx_hold <= '0;
    end else if (w_rx_cap) begin
      r_rx_full <= 1'b1;
      r_rx_hold <= rx_data;
    end else if (w_rx_pop) begin
      r_rx_full <= 1'b0;
    end
  end

  // Cycle and retired-instruction counters; a counter-reset store wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else if (w_cnt_clr) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (inst_retire) r_inst_cnt <= r_inst_cnt + 32'd1;
    end
  end

`ifdef MMIO_BR_CNT_EN
  // Branch and taken-branch counters, cleared together with the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else begin
      if (br_inst)             r_br_cnt    <= r_br_cnt + 32'd1;
      if (br_inst && br_taken) r_taken_cnt <= r_taken_cnt + 32'd1;
    end
  end
  assign w_unused = ^{addr[31:8], addr[1:0], din[31:8]};
`else
  assign r_br_cnt    = '0;
  assign r_taken_cnt = '0;
  assign w_unused    = ^{addr[31:8], addr[1:0], din[31:8], br_inst, br_taken};
`endif

endmodule
